negedge_capture_arbiter: RTL

NEGEDGE_CAPTURE_ARBITER -- requirements
Module: negedge_capture_arbiter

---
 rtl/negedge_capture_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/negedge_capture_arbiter.sv
// negedge_capture_arbiter
//   Round-robin arbiter that feeds N_REQ requesters into a single capture
//   register. The register accepts one new capture per cycle whenever it is
//   empty or is being drained in the same cycle. All flops update on the
//   falling edge of clk. Reset is asynchronous and active-high.
//
// Ports
//   clk         : clock, falling edge active
//   rst         : asynchronous active-high reset
//   req         : per-requester request, held until granted
//   req_data    : requester i data on bits [i*DW +: DW]
//   gnt         : one-hot combinational grant, high in the cycle whose
//                 closing negedge captures that requester
//   out_valid   : capture register holds unconsumed data
//   out_data    : captured data
//   out_src     : index of the requester that supplied out_data
//   out_ready   : consumer accepts out_data when out_valid is also high
//   grant_count : captures since reset, saturating at 16'hFFFF
module negedge_capture_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(N_REQ)-1:0] out_src,
  input  logic                     out_ready,
  output logic [15:0]              grant_count
);

  localparam int SW = $clog2(N_REQ);
  localparam int unsigned NR = N_REQ;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] win;
  logic          any_req;
  logic          load;

  assign any_req   = |req;
  assign out_valid = (state == FULL);
  assign load      = any_req && ((state == EMPTY) || out_ready);

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    int unsigned   idx;
    logic          found;
    logic [SW-1:0] idx_s;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NR) idx = idx - NR;
      idx_s = SW'(idx);
      if (!found && req[idx_s]) begin
        found = 1'b1;
        win   = idx_s;
      end
    end
  end

  // Grant is suppressed during reset even though the state is already cleared.
  always_comb begin
    gnt = '0;
    if (!rst && load) gnt[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (out_ready && !any_req) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
    if (load) begin
      if (win == SW'(N_REQ - 1)) ptr_nxt = '0;
      else                       ptr_nxt = win + 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_src     <= '0;
      grant_count <= '0;
    end else if (load) begin
      out_data <= req_data[int'(win)*DW +: DW];
      out_src  <= win;
      if (grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
    end
  end

endmodule
